// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares dmem port A between CPU memory stage and a DMA/boot requester
// Single-cycle arbitration, locked DMA bursts, starvation guard and read-return tagging.
module dmem_port_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int BURST_MAX  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [3:0]        cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              dma_req,
  input  logic              dma_lock,
  input  logic [3:0]        dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int BW = $clog2(BURST_MAX + 1);

  typedef enum logic [0:0] {ARB, BURST} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_t;

  state_t        state_q, state_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic          yield_q, yield_d;
  owner_t        rd_owner_q, rd_owner_d;

  logic          dma_sel;
  logic          cpu_gnt;
  logic          burst_max_hit;
  logic [BW-1:0] burst_cnt_inc;

  // Grants are suppressed while reset is asserted so nothing reaches the RAM.
  always_comb begin
    dma_sel = 1'b0;
    if (state_q == BURST) begin
      dma_sel = 1'b1;
    end else if (dma_req) begin
      dma_sel = !cpu_req || ((starve_cnt_q == SW'(STARVE_MAX)) && !yield_q);
    end
  end

  assign dma_gnt   = rst & dma_req & dma_sel;
  assign cpu_gnt   = rst & cpu_req & ~dma_sel & (state_q == ARB);
  assign cpu_stall = cpu_req & ~cpu_gnt;

  always_comb begin
    mem_addr = '0;
    mem_we   = 4'h0;
    mem_din  = '0;
    if (cpu_gnt) begin
      mem_addr = cpu_addr;
      mem_we   = cpu_we;
      mem_din  = cpu_wdata;
    end else if (dma_gnt) begin
      mem_addr = dma_addr;
      mem_we   = dma_we;
      mem_din  = dma_wdata;
    end
  end

  always_comb begin
    state_d       = state_q;
    burst_cnt_d   = burst_cnt_q;
    yield_d       = 1'b0;
    starve_cnt_d  = '0;
    rd_owner_d    = OWN_NONE;
    burst_max_hit = 1'b0;
    burst_cnt_inc = burst_cnt_q + 1'b1;

    if (dma_req && !dma_gnt) begin
      starve_cnt_d = (starve_cnt_q == SW'(STARVE_MAX)) ? starve_cnt_q : starve_cnt_q + 1'b1;
    end

    if (cpu_gnt && (cpu_we == 4'h0)) begin
      rd_owner_d = OWN_CPU;
    end else if (dma_gnt && (dma_we == 4'h0)) begin
      rd_owner_d = OWN_DMA;
    end

    // burst_cnt counts grants in the burst, including the one that opened it.
    case (state_q)
      ARB: begin
        if (dma_gnt && dma_lock) begin
          state_d     = BURST;
          burst_cnt_d = BW'(1);
        end
      end
      BURST: begin
        burst_max_hit = dma_gnt && (burst_cnt_inc == BW'(BURST_MAX));
        if (dma_gnt) begin
          burst_cnt_d = burst_cnt_inc;
        end
        if (!dma_lock || !dma_req || burst_max_hit) begin
          state_d     = ARB;
          burst_cnt_d = '0;
          yield_d     = burst_max_hit;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB;
      starve_cnt_q <= '0;
      burst_cnt_q  <= '0;
      yield_q      <= 1'b0;
      rd_owner_q   <= OWN_NONE;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
      yield_q      <= yield_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  assign cpu_rvalid = (rd_owner_q == OWN_CPU);
  assign dma_rvalid = (rd_owner_q == OWN_DMA);
  assign cpu_rdata  = cpu_rvalid ? mem_dout : '0;
  assign dma_rdata  = dma_rvalid ? mem_dout : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - self-checking bench for dmem_port_arbiter
module tb_dmem_port_arbiter;
  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int BURST_MAX  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cpu_req = 1'b0;
  logic [3:0]        cpu_we = 4'h0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_stall;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
  logic              dma_req = 1'b0;
  logic              dma_lock = 1'b0;
  logic [3:0]        dma_we = 4'h0;
  logic [ADDR_W-1:0] dma_addr = '0;
  logic [DATA_W-1:0] dma_wdata = '0;
  logic              dma_gnt;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_rvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_we;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout = '0;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, kept as plain counters and flags.
  bit              m_burst;
  int              m_starve;
  int              m_grants;
  bit              m_yield;
  int              m_rd;
  logic [ADDR_W-1:0] m_rd_addr;
  int              dma_run;
  int              dma_run_max;

  dmem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .BURST_MAX(BURST_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .dma_req(dma_req), .dma_lock(dma_lock), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] ram_word(input logic [ADDR_W-1:0] a);
    return {a, 8'h5A, ~a};
  endfunction

  // Memory stand-in: registered read whose data encodes the address read.
  always @(posedge clk) mem_dout <= ram_word(mem_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_burst  = 0;
    m_starve = 0;
    m_grants = 0;
    m_yield  = 0;
    m_rd     = 0;
    m_rd_addr = '0;
  endtask

  task automatic step(input bit cr, input logic [3:0] cw, input logic [ADDR_W-1:0] ca,
                      input bit dr, input bit dl, input logic [3:0] dw, input logic [ADDR_W-1:0] da);
    logic [DATA_W-1:0] cd, dd, xd;
    logic [3:0]        xw;
    logic [ADDR_W-1:0] xa;
    bit                e_cpu, e_dma;
    int                next_rd;
    logic [ADDR_W-1:0] next_addr;
    cd = $urandom;
    dd = $urandom;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_lock = dl; dma_we = dw; dma_addr = da; dma_wdata = dd;
    #3;
    if (!rst) begin
      e_cpu = 0; e_dma = 0;
    end else if (m_burst) begin
      e_cpu = 0; e_dma = dr;
    end else if (cr && dr) begin
      e_dma = (m_starve == STARVE_MAX) && !m_yield;
      e_cpu = !e_dma;
    end else begin
      e_cpu = cr; e_dma = dr;
    end
    xw = 4'h0; xa = '0; xd = '0;
    if (e_cpu) begin
      xw = cw; xa = ca; xd = cd;
    end else if (e_dma) begin
      xw = dw; xa = da; xd = dd;
    end
    chk("cpu_stall", cpu_stall, cr && !e_cpu);
    chk("dma_gnt", dma_gnt, e_dma);
    chk("mem_we", mem_we, xw);
    chk("mem_addr", mem_addr, xa);
    chk("mem_din", mem_din, xd);
    chk("cpu_rvalid", cpu_rvalid, m_rd == 1);
    chk("dma_rvalid", dma_rvalid, m_rd == 2);
    chk("cpu_rdata", cpu_rdata, (m_rd == 1) ? ram_word(m_rd_addr) : '0);
    chk("dma_rdata", dma_rdata, (m_rd == 2) ? ram_word(m_rd_addr) : '0);
    dma_run = dma_gnt ? dma_run + 1 : 0;
    if (dma_run > dma_run_max) dma_run_max = dma_run;
    @(posedge clk);
    #1;
    if (!rst) begin
      model_reset();
    end else begin
      next_rd = 0;
      next_addr = '0;
      if (e_cpu && cw == 4'h0) begin
        next_rd = 1; next_addr = ca;
      end else if (e_dma && dw == 4'h0) begin
        next_rd = 2; next_addr = da;
      end
      m_starve = (dr && !e_dma) ? ((m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX) : 0;
      m_yield = 0;
      if (m_burst) begin
        if (e_dma) m_grants++;
        if (m_grants == BURST_MAX) begin
          m_burst = 0; m_grants = 0; m_yield = 1;
        end else if (!dl || !dr) begin
          m_burst = 0; m_grants = 0;
        end
      end else if (e_dma && dl) begin
        m_burst = 1; m_grants = 1;
      end
      m_rd = next_rd;
      m_rd_addr = next_addr;
    end
  endtask

  task automatic idle();
    step(0, 4'h0, '0, 0, 0, 4'h0, '0);
  endtask

  initial begin
    model_reset();
    dma_run = 0;
    dma_run_max = 0;
    rst = 1'b0;
    #1;
    step(1, 4'hF, 12'h003, 1, 1, 4'hF, 12'h007);
    step(1, 4'hF, 12'h003, 1, 1, 4'hF, 12'h007);
    rst = 1'b1;

    step(1, 4'h0, 12'h010, 0, 0, 4'h0, '0);
    idle();

    for (int i = 0; i < 7; i++) step(1, 4'h0, 12'($urandom), 1, 0, 4'h0, 12'($urandom));
    idle();

    dma_run = 0;
    dma_run_max = 0;
    for (int i = 0; i < 24; i++) step(1, 4'h0, 12'($urandom), 1, 1, 4'h0, 12'($urandom));
    chk("burst_len", 64'(dma_run_max), 64'(BURST_MAX));
    idle();

    for (int i = 0; i < 3; i++) step(0, 4'h0, '0, 1, 1, 4'h0, 12'($urandom));
    idle();
    step(1, 4'hF, 12'($urandom), 0, 0, 4'h0, '0);
    idle();

    step(0, 4'h0, '0, 1, 0, 4'h0, 12'h005);
    step(1, 4'hF, 12'h006, 0, 0, 4'h0, '0);
    idle();

    for (int i = 0; i < 5; i++) step(0, 4'h0, '0, 1, 1, 4'h0, 12'($urandom));
    #2;
    chk("pre_rst_dma_rvalid", dma_rvalid, m_rd == 2);
    rst = 1'b0;
    #1;
    chk("rst_dma_rvalid", dma_rvalid, 1'b0);
    chk("rst_cpu_rvalid", cpu_rvalid, 1'b0);
    chk("rst_dma_rdata", dma_rdata, '0);
    model_reset();
    @(posedge clk);
    #1;
    step(1, 4'h0, 12'h020, 1, 1, 4'h0, 12'h021);
    rst = 1'b1;
    step(1, 4'h0, 12'h030, 0, 0, 4'h0, '0);
    idle();

    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom),
           12'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
           ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom), 12'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
